debounce_toggle_n: RTL and testbench

DEBOUNCE_TOGGLE_N -- requirements
Module: debounce_toggle_n

---
 rtl/debounce_toggle_n.sv | 71 +++++++
 tb/tb_debounce_toggle_n.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/debounce_toggle_n.sv
// Multi-channel switch debouncer with a per-channel LED that either toggles on the
// selected debounced edge or simply follows the debounced level.
module debounce_toggle_n #(
    parameter int                NUM_CH         = 4,
    parameter int                DEBOUNCE_LIMIT = 250000,
    parameter logic [NUM_CH-1:0] TOGGLE_MASK    = '1,
    parameter bit                EDGE_SEL       = 1'b1
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic [NUM_CH-1:0] i_Switch,
    output logic [NUM_CH-1:0] o_LED,
    output logic [NUM_CH-1:0] o_Event,
    output logic [NUM_CH-1:0] o_Switch_Db
);

    localparam int              CW       = $clog2(DEBOUNCE_LIMIT);
    localparam logic [CW-1:0]   LIMIT_M1 = CW'(DEBOUNCE_LIMIT - 1);

    logic [NUM_CH-1:0]          s1_q, s1_d;
    logic [NUM_CH-1:0]          s2_q, s2_d;
    logic [NUM_CH-1:0]          db_q, db_d;
    logic [NUM_CH-1:0]          led_q, led_d;
    logic [NUM_CH-1:0]          event_q, event_d;
    logic [NUM_CH-1:0][CW-1:0]  cnt_q, cnt_d;

    always_comb begin
        s1_d    = i_Switch;
        s2_d    = s1_q;
        db_d    = db_q;
        cnt_d   = cnt_q;
        event_d = '0;
        led_d   = led_q;
        for (int i = 0; i < NUM_CH; i++) begin
            // Any return to the accepted level restarts the stability count.
            if (s2_q[i] == db_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == LIMIT_M1) begin
                db_d[i]  = s2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
            event_d[i] = (db_d[i] != db_q[i]) && (db_d[i] == !EDGE_SEL);
            led_d[i]   = TOGGLE_MASK[i] ? (led_q[i] ^ event_d[i]) : db_d[i];
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            s1_q    <= '0;
            s2_q    <= '0;
            db_q    <= '0;
            cnt_q   <= '0;
            led_q   <= '0;
            event_q <= '0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
            led_q   <= led_d;
            event_q <= event_d;
        end
    end

    assign o_LED       = led_q;
    assign o_Event     = event_q;
    assign o_Switch_Db = db_q;

endmodule

// File: tb/tb_debounce_toggle_n.sv
// Scoreboard bench: stimulus queues expected output changes tagged with the edge they
// should appear at; a negedge monitor pops one entry per observed output change.
module tb_debounce_toggle_n;

    logic       i_Clk = 1'b0;
    logic       i_Rst = 1'b1;
    logic [1:0] i_Switch = 2'b00;
    logic [1:0] o_LED;
    logic [1:0] o_Event;
    logic [1:0] o_Switch_Db;

    typedef struct {
        int         edge_n;
        logic [5:0] val;
        string      name;
    } exp_t;

    exp_t       exp_q[$];
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;
    bit         mon_en = 1'b0;
    logic [5:0] prev_val = '0;
    bit         count_ev0 = 1'b0;
    int         ev0_pulses = 0;

    debounce_toggle_n #(
        .NUM_CH(2),
        .DEBOUNCE_LIMIT(4),
        .TOGGLE_MASK(2'b01),
        .EDGE_SEL(1'b1)
    ) dut (
        .i_Clk(i_Clk),
        .i_Rst(i_Rst),
        .i_Switch(i_Switch),
        .o_LED(o_LED),
        .o_Event(o_Event),
        .o_Switch_Db(o_Switch_Db)
    );

    always #5 i_Clk = ~i_Clk;

    always @(posedge i_Clk) cyc++;

    task automatic checkOutput(input string name, input int got_edge, input logic [5:0] got,
                               input int exp_edge, input logic [5:0] exp_val);
        n_cmp++;
        if (got !== exp_val || got_edge != exp_edge) begin
            n_bad++;
            $display("[TB] FAIL %s: got {led,ev,db}=%b at edge %0d, expected %b at edge %0d",
                     name, got, got_edge, exp_val, exp_edge);
        end
    endtask

    // Values are {o_LED, o_Event, o_Switch_Db}; a level change lands 6 edges after the drive.
    task automatic applyStimulus(input string name, input logic [1:0] sw, input int hold,
                                 input int n_exp, input logic [5:0] val_a, input logic [5:0] val_b);
        int d;
        d = cyc;
        i_Switch = sw;
        if (n_exp > 0) exp_q.push_back('{d + 6, val_a, {name, "_edge"}});
        if (n_exp > 1) exp_q.push_back('{d + 7, val_b, {name, "_pulse_end"}});
        repeat (hold) @(negedge i_Clk);
    endtask

    always @(negedge i_Clk) begin
        logic [5:0] cur;
        exp_t       e;
        if (mon_en) begin
            cur = {o_LED, o_Event, o_Switch_Db};
            if (count_ev0 && o_Event[0]) ev0_pulses++;
            if (cur != prev_val) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("[TB] FAIL unexpected_change: got %b at edge %0d, expected no change from %b",
                             cur, cyc, prev_val);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput(e.name, cyc, cur, e.edge_n, e.val);
                end
                prev_val = cur;
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int d;
        repeat (3) @(negedge i_Clk);
        i_Rst = 1'b0;
        checkOutput("reset_state", cyc, {o_LED, o_Event, o_Switch_Db}, cyc, 6'b00_00_00);
        prev_val = {o_LED, o_Event, o_Switch_Db};
        mon_en = 1'b1;

        applyStimulus("a_press",   2'b01, 20, 1, 6'b00_00_01, 6'b0);
        applyStimulus("a_release", 2'b00, 12, 2, 6'b01_01_00, 6'b01_00_00);

        for (int k = 0; k < 10; k++) begin
            applyStimulus("b_glitch_hi", 2'b01, 3, 0, 6'b0, 6'b0);
            applyStimulus("b_glitch_lo", 2'b00, 3, 0, 6'b0, 6'b0);
        end
        applyStimulus("b_idle", 2'b00, 10, 0, 6'b0, 6'b0);
        checkOutput("b_glitch_quiet", cyc, {o_LED, o_Event, o_Switch_Db}, cyc, 6'b01_00_00);

        applyStimulus("c_press",   2'b10, 10, 1, 6'b11_00_10, 6'b0);
        applyStimulus("c_release", 2'b00, 12, 2, 6'b01_10_00, 6'b01_00_00);

        applyStimulus("d_press",   2'b11, 10, 1, 6'b11_00_11, 6'b0);
        applyStimulus("d_release", 2'b00, 12, 2, 6'b00_11_00, 6'b00_00_00);

        count_ev0 = 1'b1;
        applyStimulus("e_press1",   2'b01, 10, 1, 6'b00_00_01, 6'b0);
        applyStimulus("e_release1", 2'b00, 10, 2, 6'b01_01_00, 6'b01_00_00);
        applyStimulus("e_press2",   2'b01, 10, 1, 6'b01_00_01, 6'b0);
        applyStimulus("e_release2", 2'b00, 12, 2, 6'b00_01_00, 6'b00_00_00);
        count_ev0 = 1'b0;
        checkOutput("e_event_count", cyc, 6'(ev0_pulses), cyc, 6'd2);

        // Reset lands while ch0's count sits at 2 and ch1 is already accepted high.
        applyStimulus("f_ch1_press", 2'b10, 10, 1, 6'b10_00_10, 6'b0);
        d = cyc;
        i_Switch = 2'b11;
        exp_q.push_back('{d + 5, 6'b00_00_00, "f_reset_clear"});
        exp_q.push_back('{d + 11, 6'b10_00_11, "f_repress"});
        repeat (4) @(negedge i_Clk);
        i_Rst = 1'b1;
        @(negedge i_Clk);
        checkOutput("f_reset_direct", cyc, {o_LED, o_Event, o_Switch_Db}, d + 5, 6'b00_00_00);
        i_Rst = 1'b0;
        repeat (10) @(negedge i_Clk);
        applyStimulus("f_release", 2'b00, 12, 2, 6'b01_11_00, 6'b01_00_00);

        repeat (3) @(negedge i_Clk);
        checkOutput("scoreboard_drained", cyc, 6'(exp_q.size()), cyc, 6'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
